// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I integer register file: data width,
// register address width, the hardwired-zero register index and a data word type.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [XLEN-1:0] word_t;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port of the register file: 32:1 mux over the
// register view, x0 forced to zero, and optional write-through forwarding
// enabled by the RISCV_RF_BYPASS_EN macro.
module rf_read_port #(
  parameter int XLEN     = riscv_pkg::XLEN,
  parameter int NUM_REGS = riscv_pkg::NUM_REGS
) (
  input  logic [riscv_pkg::REG_ADDR_W-1:0] addr,
  input  logic [NUM_REGS-1:0][XLEN-1:0]    regs,
`ifdef RISCV_RF_BYPASS_EN
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] wr_addr,
  input  logic [XLEN-1:0]                  wr_data,
`endif
  output logic [XLEN-1:0]                  data
);

  import riscv_pkg::*;

`ifdef RISCV_RF_BYPASS_EN
  logic fwd_hit;

  // Forward the in-flight write when it targets this port's address;
  // never while reset is asserted, since that write will be dropped.
  always_comb begin
    fwd_hit = !rst && wr_en && (wr_addr != REG_ZERO) && (wr_addr == addr);
  end
`endif

  // Select stored contents, force x0 to zero, optionally override with bypass.
  always_comb begin
    data = regs[addr];
    if (addr == REG_ZERO) begin
      data = '0;
    end
`ifdef RISCV_RF_BYPASS_EN
    if (fwd_hit) begin
      data = wr_data;
    end
`endif
  end

endmodule

// File: rtl/riscv_register_file.sv
// RV32I integer register file: x1..x31 storage, two combinational read
// ports, one synchronous write port, x0 hardwired to zero.
// Optional macro RISCV_RF_BYPASS_EN adds write-through forwarding on both
// read ports; storage and write behaviour are the same in both builds.
module riscv_register_file #(
  parameter int XLEN     = riscv_pkg::XLEN,
  parameter int NUM_REGS = riscv_pkg::NUM_REGS
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] rs1,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] rs2,
  output logic [XLEN-1:0]                  output1,
  output logic [XLEN-1:0]                  output2,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] rd,
  input  logic [XLEN-1:0]                  write_data,
  input  logic                             reg_write
);

  import riscv_pkg::*;

  // x0 has no storage; entries start at index 1.
  logic [XLEN-1:0]               mem [1:NUM_REGS-1];
  logic [NUM_REGS-1:0][XLEN-1:0] regs_view;

  // Reset clears every register and wins over a simultaneous write;
  // writes to x0 never match any storage entry and are discarded.
  always_ff @(posedge clk) begin
    for (int i = 1; i < NUM_REGS; i++) begin
      if (rst) begin
        mem[i] <= '0;
      end else if (reg_write && (rd == REG_ADDR_W'(i))) begin
        mem[i] <= write_data;
      end
    end
  end

  assign regs_view[0] = '0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_view
    assign regs_view[g] = mem[g];
  end

  rf_read_port #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS)
  ) u_port1 (
    .addr    (rs1),
    .regs    (regs_view),
`ifdef RISCV_RF_BYPASS_EN
    .rst     (rst),
    .wr_en   (reg_write),
    .wr_addr (rd),
    .wr_data (write_data),
`endif
    .data    (output1)
  );

  rf_read_port #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS)
  ) u_port2 (
    .addr    (rs2),
    .regs    (regs_view),
`ifdef RISCV_RF_BYPASS_EN
    .rst     (rst),
    .wr_en   (reg_write),
    .wr_addr (rd),
    .wr_data (write_data),
`endif
    .data    (output2)
  );

endmodule

// File: tb/tb_riscv_register_file.sv
// Self-checking bench for riscv_register_file: directed scenarios followed by
// randomized traffic, compared against an array model of the register file.
module tb_riscv_register_file;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [31:0] output1;
  logic [31:0] output2;
  logic [4:0]  rd = '0;
  logic [31:0] write_data = '0;
  logic        reg_write = 1'b0;

  int checks = 0;
  int errors = 0;

  // Architectural state as seen by software; index 0 is unused.
  logic [31:0] model [32];

  riscv_register_file dut (
    .clk        (clk),
    .rst        (rst),
    .rs1        (rs1),
    .rs2        (rs2),
    .output1    (output1),
    .output2    (output2),
    .rd         (rd),
    .write_data (write_data),
    .reg_write  (reg_write)
  );

  always #5 clk = ~clk;

  // What a read of address a should return given the currently driven inputs.
  function automatic logic [31:0] expect_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef RISCV_RF_BYPASS_EN
    if (!rst && reg_write && rd == a) return write_data;
`endif
    return model[a];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, optionally check before the edge, then apply
  // the architectural rules to the model at the edge and check after it.
  task automatic step(input string tag, input logic r, input logic we,
                      input logic [4:0] a_rd, input logic [31:0] wd,
                      input logic [4:0] a1, input logic [4:0] a2,
                      input bit chk_pre);
    rst = r; reg_write = we; rd = a_rd; write_data = wd; rs1 = a1; rs2 = a2;
    #2;
    if (chk_pre) begin
      check({tag, "_pre1"}, output1, expect_rd(a1));
      check({tag, "_pre2"}, output2, expect_rd(a2));
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (we && a_rd != 5'd0) begin
      model[a_rd] = wd;
    end
    #1;
    check({tag, "_post1"}, output1, expect_rd(a1));
    check({tag, "_post2"}, output2, expect_rd(a2));
  endtask

  initial begin
    logic [31:0] exp_pre;
    for (int i = 0; i < 32; i++) model[i] = 'x;

    // x0 reads zero even before any reset.
    #2;
    check("x0_before_reset", output1, 32'h0);

    // Reset edge, then x0 and x1 both read zero.
    step("reset", 1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd1, 1'b0);
    step("after_reset", 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd1, 1'b1);
    check("after_reset_x0_const", output1, 32'h0);
    check("after_reset_x1_const", output2, 32'h0);

    // Two writes, then read both back.
    step("wr_x1", 1'b0, 1'b1, 5'd1, 32'hDEADBEEF, 5'd1, 5'd2, 1'b1);
    step("wr_x2", 1'b0, 1'b1, 5'd2, 32'h12345678, 5'd1, 5'd2, 1'b1);
    step("rd_x1_x2", 1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 1'b1);
    check("x1_const", output1, 32'hDEADBEEF);
    check("x2_const", output2, 32'h12345678);

    // Write to x0 discarded.
    step("wr_x0", 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1);
    check("x0_const", output1, 32'h0);

    // reg_write low leaves x1 untouched; both ports on the same register.
    step("no_we", 1'b0, 1'b0, 5'd1, 32'hAAAAAAAA, 5'd1, 5'd1, 1'b1);
    check("x1_kept_const", output1, 32'hDEADBEEF);
    check("same_reg_both_ports", output2, 32'hDEADBEEF);

    // Same-cycle read of x3 while it is written.
`ifdef RISCV_RF_BYPASS_EN
    exp_pre = 32'hCAFEF00D;
`else
    exp_pre = 32'h0;
`endif
    rst = 1'b0; reg_write = 1'b1; rd = 5'd3; write_data = 32'hCAFEF00D; rs1 = 5'd3; rs2 = 5'd1;
    #2;
    check("x3_same_cycle_const", output1, exp_pre);
    step("wr_x3", 1'b0, 1'b1, 5'd3, 32'hCAFEF00D, 5'd3, 5'd1, 1'b1);
    check("x3_after_edge_const", output1, 32'hCAFEF00D);

    // Reset wins over a simultaneous write to x4; all registers read zero.
    step("rst_with_wr", 1'b1, 1'b1, 5'd4, 32'h55555555, 5'd4, 5'd1, 1'b1);
    reg_write = 1'b0; rst = 1'b0;
    for (int i = 1; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i + 1);
      #1;
      check($sformatf("clr_x%0d", i), output1, 32'h0);
    end
    @(negedge clk);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 300; n++) begin
      step($sformatf("rand%0d", n),
           ($urandom_range(0, 31) == 0),
           1'($urandom_range(0, 1)),
           5'($urandom_range(0, 31)),
           $urandom,
           5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)),
           1'b1);
    end

    // Sweep every register against the model.
    step("sweep_idle", 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(i);
      #1;
      check($sformatf("sweep_x%0d", i), output1, (i == 0) ? 32'h0 : model[i]);
      check($sformatf("sweep2_x%0d", i), output2, output1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
